pipeline_stage_chain: RTL and testbench

- Parametrised generalisation of the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register set: STAGES inter-stage registers of DATA_SZ bits each.
- Each register has its own valid and halt bits, per-stage stall and flush, and automatic bubble insertion.
- Adds a debug single-step mode, a sticky halt freeze and cycle/retire counters.
- Sits between the stage combinational blocks and the debug unit; replaces the individual *_reg instances in the next core revision.

---
 rtl/pipeline_stage_chain.sv | 121 ++++++++++++
 tb/tb_pipeline_stage_chain.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_chain.sv
// Parametrised chain of inter-stage pipeline registers with per-stage stall/flush,
// bubble insertion, debug single-step, sticky halt freeze and cycle/retire counters.
module pipeline_stage_chain #(
  parameter int STAGES  = 4,
  parameter int DATA_SZ = 64,
  parameter int CNT_SZ  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_step_mode,
  input  logic                        i_step,
  input  logic                        i_valid,
  input  logic                        i_halt,
  input  logic [STAGES-1:0]           i_stall,
  input  logic [STAGES-1:0]           i_flush,
  input  logic [STAGES*DATA_SZ-1:0]   i_stage_d,
  output logic [STAGES*DATA_SZ-1:0]   o_stage_q,
  output logic [STAGES-1:0]           o_valid,
  output logic                        o_advance,
  output logic                        o_halt,
  output logic [CNT_SZ-1:0]           o_cycle_cnt,
  output logic [CNT_SZ-1:0]           o_retired_cnt
);

  localparam int LAST = STAGES - 1;

  logic [DATA_SZ-1:0] data_q [STAGES];
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  halt_q;
  logic               halt_sticky;
  logic [CNT_SZ-1:0]  cycle_cnt;
  logic [CNT_SZ-1:0]  retired_cnt;

  logic               advance;
  logic [STAGES-1:0]  hold;
  logic [STAGES-1:0]  up_hold;
  logic [STAGES-1:0]  src_valid;
  logic [STAGES-1:0]  src_halt;
  logic               load_last;
  logic               retire;
  logic               halt_set;

  assign advance = i_enable & ~halt_sticky & (~i_step_mode | i_step);

  // A stall anywhere downstream freezes this register as well.
  always_comb begin
    hold      = '0;
    up_hold   = '0;
    src_valid = '0;
    src_halt  = '0;
    hold[LAST] = i_stall[LAST];
    for (int k = LAST - 1; k >= 0; k--) begin
      hold[k] = i_stall[k] | hold[k+1];
    end
    src_valid[0] = i_valid;
    src_halt[0]  = i_halt;
    for (int k = 1; k < STAGES; k++) begin
      up_hold[k]   = hold[k-1];
      src_valid[k] = valid_q[k-1];
      src_halt[k]  = halt_q[k-1];
    end
  end

  assign load_last = ~i_flush[LAST] & ~hold[LAST] & ~up_hold[LAST];
  assign retire    = advance & ~i_flush[LAST] & ~hold[LAST] & valid_q[LAST];
  assign halt_set  = advance & load_last & src_valid[LAST] & src_halt[LAST];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
      valid_q     <= '0;
      halt_q      <= '0;
      halt_sticky <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (i_flush[k]) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
          halt_q[k]  <= 1'b0;
        end else if (hold[k]) begin
          data_q[k]  <= data_q[k];
          valid_q[k] <= valid_q[k];
          halt_q[k]  <= halt_q[k];
        end else if (up_hold[k]) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
          halt_q[k]  <= 1'b0;
        end else begin
          data_q[k]  <= i_stage_d[k*DATA_SZ +: DATA_SZ];
          valid_q[k] <= src_valid[k];
          halt_q[k]  <= src_halt[k];
        end
      end
      if (halt_set) begin
        halt_sticky <= 1'b1;
      end
      if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + CNT_SZ'(1);
      end
      if (retire && (retired_cnt != '1)) begin
        retired_cnt <= retired_cnt + CNT_SZ'(1);
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign o_stage_q[k*DATA_SZ +: DATA_SZ] = data_q[k];
  end

  assign o_valid       = valid_q;
  assign o_advance     = advance;
  assign o_halt        = halt_sticky;
  assign o_cycle_cnt   = cycle_cnt;
  assign o_retired_cnt = retired_cnt;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed bench for pipeline_stage_chain with STAGES=4, DATA_SZ=8, CNT_SZ=8.
module tb_pipeline_stage_chain;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_step_mode;
  logic        i_step;
  logic        i_valid;
  logic        i_halt;
  logic [3:0]  i_stall;
  logic [3:0]  i_flush;
  logic [31:0] i_stage_d;
  logic [31:0] o_stage_q;
  logic [3:0]  o_valid;
  logic        o_advance;
  logic        o_halt;
  logic [7:0]  o_cycle_cnt;
  logic [7:0]  o_retired_cnt;

  int total;
  int bad;

  pipeline_stage_chain #(.STAGES(4), .DATA_SZ(8), .CNT_SZ(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_step_mode(i_step_mode), .i_step(i_step), .i_valid(i_valid),
    .i_halt(i_halt), .i_stall(i_stall), .i_flush(i_flush),
    .i_stage_d(i_stage_d), .o_stage_q(o_stage_q), .o_valid(o_valid),
    .o_advance(o_advance), .o_halt(o_halt), .o_cycle_cnt(o_cycle_cnt),
    .o_retired_cnt(o_retired_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"}, o_stage_q, 32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_halt"}, 32'(o_halt), 32'h0);
    chk({tag, "_cyc"}, 32'(o_cycle_cnt), 32'h0);
    chk({tag, "_ret"}, 32'(o_retired_cnt), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_reset = 1'b0; i_enable = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_valid = 1'b0; i_halt = 1'b0; i_stall = '0; i_flush = '0; i_stage_d = '0;
    #2;
    chk_all_zero("reset_async");
    i_enable = 1'b1; i_valid = 1'b1; i_stage_d = 32'h44332211;
    tick(); tick();
    chk_all_zero("reset_held");
    i_reset = 1'b1;

    // Free run
    chk("adv_free", 32'(o_advance), 32'h1);
    tick(); chk("fr_valid1", 32'(o_valid), 32'h1);
    tick(); chk("fr_valid2", 32'(o_valid), 32'h3);
    tick(); chk("fr_valid3", 32'(o_valid), 32'h7);
    tick(); chk("fr_valid4", 32'(o_valid), 32'hF);
    chk("fr_q4", o_stage_q, 32'h44332211);
    chk("fr_ret4", 32'(o_retired_cnt), 32'h0);
    tick(); tick();
    chk("fr_cyc6", 32'(o_cycle_cnt), 32'd6);
    chk("fr_ret6", 32'(o_retired_cnt), 32'd2);

    // Stall on register 1
    i_stage_d = 32'h88776655;
    i_stall = 4'b0010;
    tick();
    i_stall = 4'b0000;
    chk("st_q", o_stage_q, 32'h88002211);
    chk("st_valid", 32'(o_valid), 32'hB);
    chk("st_cyc", 32'(o_cycle_cnt), 32'd7);
    chk("st_ret", 32'(o_retired_cnt), 32'd3);

    // Flush and stall together on register 2
    i_stall = 4'b0100; i_flush = 4'b0100;
    tick();
    i_stall = 4'b0000; i_flush = 4'b0000;
    chk("fl_q", o_stage_q, 32'h00002211);
    chk("fl_valid", 32'(o_valid), 32'h3);
    chk("fl_cyc", 32'(o_cycle_cnt), 32'd8);
    chk("fl_ret", 32'(o_retired_cnt), 32'd4);

    // Halt entry travels to the last register
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    chk("h_valid1", 32'(o_valid), 32'h7);
    tick(); tick();
    chk("h_not_yet", 32'(o_halt), 32'h0);
    tick();
    chk("h_set", 32'(o_halt), 32'h1);
    chk("h_adv", 32'(o_advance), 32'h0);
    chk("h_cyc", 32'(o_cycle_cnt), 32'd12);
    chk("h_ret", 32'(o_retired_cnt), 32'd6);
    chk("h_q", o_stage_q, 32'h88776655);
    i_stage_d = 32'hAAAAAAAA; i_flush = 4'b1111;
    tick(); tick(); tick();
    i_flush = 4'b0000;
    chk("hf_q", o_stage_q, 32'h88776655);
    chk("hf_valid", 32'(o_valid), 32'hF);
    chk("hf_cyc", 32'(o_cycle_cnt), 32'd12);
    chk("hf_ret", 32'(o_retired_cnt), 32'd6);
    chk("hf_halt", 32'(o_halt), 32'h1);

    i_reset = 1'b0;
    #1;
    chk_all_zero("h_reset");
    tick();
    i_reset = 1'b1;

    // Step mode: three single-cycle pulses over 20 cycles
    i_step_mode = 1'b1;
    i_stage_d = 32'hD4C3B2A1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      i_step  = (cyc == 3 || cyc == 10 || cyc == 17);
      i_valid = (cyc == 3);
      #1;
      chk("sm_adv", 32'(o_advance), 32'(i_step));
      tick();
    end
    i_step = 1'b0; i_valid = 1'b0;
    chk("sm_cyc", 32'(o_cycle_cnt), 32'd3);
    chk("sm_valid", 32'(o_valid), 32'h4);
    chk("sm_q", o_stage_q, 32'hD4C3B2A1);
    chk("sm_ret", 32'(o_retired_cnt), 32'd0);
    i_enable = 1'b0; i_step = 1'b1;
    tick();
    i_enable = 1'b1; i_step = 1'b0;
    chk("sm_dis_cyc", 32'(o_cycle_cnt), 32'd3);
    chk("sm_dis_valid", 32'(o_valid), 32'h4);

    i_reset = 1'b0;
    #1;
    chk_all_zero("sm_reset");
    tick();
    chk_all_zero("sm_reset_held");
    i_reset = 1'b1;

    // Saturation of both counters
    i_step_mode = 1'b0; i_valid = 1'b1;
    repeat (254) tick();
    chk("sat_cyc254", 32'(o_cycle_cnt), 32'hFE);
    tick();
    chk("sat_cyc255", 32'(o_cycle_cnt), 32'hFF);
    repeat (45) tick();
    chk("sat_cyc300", 32'(o_cycle_cnt), 32'hFF);
    chk("sat_ret300", 32'(o_retired_cnt), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
